// File: rtl/athos_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : athos_pkg                                                     |
// | Brief    : Shared constants and types for the athos coefficient packers. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package athos_pkg;

  localparam int COEFF_W = 12;
  localparam int KYBER_Q = 3329;
  localparam int WORD_W  = 32;
  // A partly drained word plus one fresh coefficient never exceeds this width.
  localparam int ACC_W   = WORD_W + COEFF_W;
  localparam int FILL_W  = 6;

  typedef logic [COEFF_W-1:0] coeff12_t;

endpackage
`default_nettype wire

// File: rtl/poly_csubq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : poly_csubq                                                    |
// | Brief    : Combinational conditional subtract of Q, truncated to 12 bits.|
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module poly_csubq
  import athos_pkg::*;
#(
  parameter int Q         = KYBER_Q,
  parameter bit REDUCE_EN = 1'b1
) (
  input  logic [15:0] i_coeff,
  output coeff12_t    o_coeff
);

  localparam logic [15:0] C_Q = 16'(Q);

  generate
    if (REDUCE_EN) begin : g_reduce
      // Out-of-range inputs (>= 2Q) simply truncate; nothing downstream depends on them.
      assign o_coeff = coeff12_t'((i_coeff >= C_Q) ? (i_coeff - C_Q) : i_coeff);
    end else begin : g_pass
      assign o_coeff = coeff12_t'(i_coeff);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/poly_tobytes_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : poly_tobytes_stream                                           |
// | Brief    : Streams 12-bit reduced coefficients into packed 32-bit words. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module poly_tobytes_stream
  import athos_pkg::*;
#(
  parameter int N_COEFF   = 256,
  parameter int Q         = KYBER_Q,
  parameter bit REDUCE_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        coeff_valid_i,
  output logic        coeff_ready_o,
  input  logic [15:0] coeff_i,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  output logic [31:0] word_o,
  output logic        word_last_o,
  output logic        done_o
);

  localparam int N_WORDS = N_COEFF * COEFF_W / WORD_W;
  localparam int CC_W    = $clog2(N_COEFF);
  localparam int WC_W    = $clog2(N_WORDS);

  localparam logic [CC_W-1:0]   C_LAST_COEFF = CC_W'(N_COEFF - 1);
  localparam logic [WC_W-1:0]   C_LAST_WORD  = WC_W'(N_WORDS - 1);
  localparam logic [FILL_W-1:0] C_WORD_BITS  = FILL_W'(WORD_W);
  localparam logic [FILL_W-1:0] C_COEFF_BITS = FILL_W'(COEFF_W);

  logic [ACC_W-1:0]  r_acc;
  logic [FILL_W-1:0] r_fill;
  logic [CC_W-1:0]   r_coeff_cnt;
  logic [WC_W-1:0]   r_word_cnt;
  logic              r_done;

  coeff12_t          w_r12;
  logic              w_word_valid;
  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_last_word;
  logic [FILL_W-1:0] w_base;
  logic [FILL_W-1:0] w_fill_nxt;
  logic [ACC_W-1:0]  w_acc_kept;
  logic [ACC_W-1:0]  w_acc_ins;
  logic [ACC_W-1:0]  w_acc_nxt;

  poly_csubq #(
    .Q         (Q),
    .REDUCE_EN (REDUCE_EN)
  ) u_csubq (
    .i_coeff (coeff_i),
    .o_coeff (w_r12)
  );

  assign w_word_valid = (r_fill >= C_WORD_BITS);
  assign w_out_fire   = w_word_valid & word_ready_i;
  // Ready looks through to the sink so a drain and a fill can share one cycle.
  assign coeff_ready_o = ~w_word_valid | word_ready_i;
  assign w_in_fire     = coeff_valid_i & coeff_ready_o;
  assign w_last_word   = (r_word_cnt == C_LAST_WORD);

  assign w_base     = w_out_fire ? (r_fill - C_WORD_BITS) : r_fill;
  assign w_acc_kept = w_out_fire ? (r_acc >> WORD_W) : r_acc;
  assign w_acc_ins  = w_in_fire ? (ACC_W'(w_r12) << w_base) : '0;
  assign w_acc_nxt  = w_acc_kept | w_acc_ins;
  assign w_fill_nxt = w_base + (w_in_fire ? C_COEFF_BITS : '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc       <= '0;
      r_fill      <= '0;
      r_coeff_cnt <= '0;
      r_word_cnt  <= '0;
      r_done      <= 1'b0;
    end else if (clear_i) begin
      r_acc       <= '0;
      r_fill      <= '0;
      r_coeff_cnt <= '0;
      r_word_cnt  <= '0;
      r_done      <= 1'b0;
    end else begin
      r_acc  <= w_acc_nxt;
      r_fill <= w_fill_nxt;
      r_done <= w_out_fire & w_last_word;
      if (w_in_fire) begin
        r_coeff_cnt <= (r_coeff_cnt == C_LAST_COEFF) ? '0 : r_coeff_cnt + CC_W'(1);
      end
      if (w_out_fire) begin
        r_word_cnt <= w_last_word ? '0 : r_word_cnt + WC_W'(1);
      end
    end
  end

  assign word_valid_o = w_word_valid;
  assign word_o       = r_acc[WORD_W-1:0];
  assign word_last_o  = w_word_valid & w_last_word;
  assign done_o       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_poly_tobytes_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_poly_tobytes_stream                                        |
// | Brief    : Self-checking bench: vector table plus bit-stream scoreboard. |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_poly_tobytes_stream;

  localparam int N_COEFF = 256;
  localparam int N_WORDS = N_COEFF * 12 / 32;
  localparam int QQ      = 3329;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        clear_i = 1'b0;
  logic        coeff_valid_i = 1'b0;
  logic        coeff_ready_o;
  logic [15:0] coeff_i = '0;
  logic        word_valid_o;
  logic        word_ready_i = 1'b0;
  logic [31:0] word_o;
  logic        word_last_o;
  logic        done_o;

  poly_tobytes_stream #(.N_COEFF(N_COEFF), .Q(QQ), .REDUCE_EN(1'b1)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .coeff_valid_i (coeff_valid_i),
    .coeff_ready_o (coeff_ready_o),
    .coeff_i       (coeff_i),
    .word_valid_o  (word_valid_o),
    .word_ready_i  (word_ready_i),
    .word_o        (word_o),
    .word_last_o   (word_last_o),
    .done_o        (done_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed { logic [31:0] w; logic last; } exp_t;
  exp_t exp_q[$];
  bit   bitq[$];
  int   model_wcnt = 0;
  logic exp_done_q = 1'b0;

  int words_fired = 0, last_cnt = 0, last_idx = -1, done_cnt = 0, ready_drops = 0;
  bit s3_active = 0;

  function automatic logic [11:0] csubq_ref(input logic [15:0] x);
    int v = int'(x);
    if (v >= QQ) v = v - QQ;
    return 12'(v);
  endfunction

  task automatic model_push(input logic [11:0] r);
    logic [31:0] w;
    for (int i = 0; i < 12; i++) bitq.push_back(r[i]);
    while (bitq.size() >= 32) begin
      w = '0;
      for (int i = 0; i < 32; i++) w[i] = bitq.pop_front();
      exp_q.push_back('{w: w, last: (model_wcnt == N_WORDS - 1)});
      model_wcnt = (model_wcnt == N_WORDS - 1) ? 0 : model_wcnt + 1;
    end
  endtask

  // Scoreboard monitor, sampling mid-cycle where inputs and outputs are stable.
  always @(negedge clk_i) begin
    exp_t e;
    logic nxt_done;
    if (!rst_ni || clear_i) begin
      exp_q.delete();
      bitq.delete();
      model_wcnt = 0;
      exp_done_q = 1'b0;
    end else begin
      chk("done_pulse", {31'b0, done_o}, {31'b0, exp_done_q});
      if (done_o) done_cnt++;
      if (s3_active && coeff_valid_i && !coeff_ready_o) ready_drops++;
      nxt_done = 1'b0;
      if (word_valid_o && word_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_word", word_o, e.w);
          chk("sb_last", {31'b0, word_last_o}, {31'b0, e.last});
          nxt_done = e.last;
        end
        if (word_last_o) begin
          last_cnt++;
          last_idx = words_fired;
        end
        words_fired++;
      end
      if (coeff_valid_i && coeff_ready_o) model_push(csubq_ref(coeff_i));
      exp_done_q = nxt_done;
    end
  end

  typedef struct packed {
    logic [15:0] c0;
    logic [15:0] c1;
    logic [15:0] c2;
    logic [31:0] word;
  } vec_t;
  vec_t vec[5];

  task automatic cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    cycle();
    clear_i = 1'b0;
  endtask

  // Three accepts into an empty packer with the sink stalled, then inspect the held word.
  task automatic feed3_check(input int idx, input bit do_clear);
    logic [15:0] c[3];
    if (do_clear) pulse_clear();
    word_ready_i = 1'b0;
    c[0] = vec[idx].c0; c[1] = vec[idx].c1; c[2] = vec[idx].c2;
    for (int k = 0; k < 3; k++) begin
      coeff_valid_i = 1'b1;
      coeff_i = c[k];
      @(negedge clk_i);
      chk("vec_early_valid", {31'b0, word_valid_o}, 32'd0);
      cycle();
    end
    coeff_valid_i = 1'b0;
    @(negedge clk_i);
    chk("vec_word", word_o, vec[idx].word);
    chk("vec_valid", {31'b0, word_valid_o}, 32'd1);
    chk("vec_backpressure", {31'b0, coeff_ready_o}, 32'd0);
    chk("vec_last", {31'b0, word_last_o}, 32'd0);
    cycle();
  endtask

  task automatic run_stream(input int n, input int pv, input int pr, output int cycles);
    int  sent = 0;
    bit  acc;
    cycles = 0;
    while (sent < n && cycles < 20000) begin
      if (!coeff_valid_i && ($urandom_range(99) < pv)) begin
        coeff_valid_i = 1'b1;
        coeff_i = 16'($urandom_range(2 * QQ - 1));
      end
      word_ready_i = ($urandom_range(99) < pr);
      @(negedge clk_i);
      acc = coeff_valid_i && coeff_ready_o;
      cycle();
      cycles++;
      if (acc) begin
        sent++;
        coeff_valid_i = 1'b0;
      end
    end
    if (sent < n) chk("stream_timeout", 32'(sent), 32'(n));
  endtask

  task automatic drain();
    int  n = 0;
    bit  busy = 1;
    coeff_valid_i = 1'b0;
    word_ready_i = 1'b1;
    while (busy && n < 300) begin
      @(negedge clk_i);
      busy = (exp_q.size() != 0) || word_valid_o;
      cycle();
      n++;
    end
    chk("drain_timeout", {31'b0, busy}, 32'd0);
    repeat (2) cycle();
  endtask

  initial begin
    int cyc;
    vec[0] = '{c0: 16'h123, c1: 16'h456, c2: 16'h789, word: 32'h89456123};
    vec[1] = '{c0: 16'd3329, c1: 16'd3328, c2: 16'd6657, word: 32'h00D00000};
    vec[2] = '{c0: 16'd3328, c1: 16'd1, c2: 16'd2, word: 32'h02001D00};
    vec[3] = '{c0: 16'd6657, c1: 16'h0CFF, c2: 16'h00AB, word: 32'hABCFFD00};
    vec[4] = '{c0: 16'd4095, c1: 16'd3330, c2: 16'h05A5, word: 32'hA50012FE};

    // Reset state
    @(negedge clk_i);
    chk("rst_word_valid", {31'b0, word_valid_o}, 32'd0);
    chk("rst_done", {31'b0, done_o}, 32'd0);
    chk("rst_coeff_ready", {31'b0, coeff_ready_o}, 32'd1);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    cycle();

    // Vector table: packing, reduction and one-cycle latency
    for (int t = 0; t < 5; t++) feed3_check(t, 1'b1);
    pulse_clear();

    // Full frame back-to-back at full rate
    words_fired = 0; last_cnt = 0; last_idx = -1; done_cnt = 0; ready_drops = 0;
    s3_active = 1;
    run_stream(N_COEFF, 100, 100, cyc);
    s3_active = 0;
    chk("s3_cycles", 32'(cyc), 32'(N_COEFF));
    drain();
    chk("s3_words", 32'(words_fired), 32'(N_WORDS));
    chk("s3_last_cnt", 32'(last_cnt), 32'd1);
    chk("s3_last_idx", 32'(last_idx), 32'(N_WORDS - 1));
    chk("s3_done_cnt", 32'(done_cnt), 32'd1);
    chk("s3_ready_drops", 32'(ready_drops), 32'd0);

    // Backpressure: word holds, ready drops, nothing lost on release
    feed3_check(0, 1'b0);
    coeff_valid_i = 1'b1;
    coeff_i = 16'h0ABC;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("s4_ready_low", {31'b0, coeff_ready_o}, 32'd0);
      chk("s4_word_hold", word_o, 32'h89456123);
      cycle();
    end
    word_ready_i = 1'b1;
    @(negedge clk_i);
    chk("s4_release_ready", {31'b0, coeff_ready_o}, 32'd1);
    cycle();
    coeff_valid_i = 1'b0;
    run_stream(N_COEFF - 4, 70, 50, cyc);
    done_cnt = 0;
    drain();
    chk("s4_done_cnt", 32'(done_cnt), 32'd1);

    // Random valid/ready against the bit-stream model, two frames
    done_cnt = 0;
    run_stream(2 * N_COEFF, 50, 50, cyc);
    drain();
    chk("s5_done_cnt", 32'(done_cnt), 32'd2);
    chk("s5_queue_empty", 32'(exp_q.size()), 32'd0);

    // Clear mid-frame, with a coefficient offered in the same cycle
    run_stream(50, 100, 100, cyc);
    coeff_valid_i = 1'b1;
    coeff_i = 16'h0777;
    word_ready_i = 1'b1;
    pulse_clear();
    coeff_valid_i = 1'b0;
    @(negedge clk_i);
    chk("clr_word_valid", {31'b0, word_valid_o}, 32'd0);
    cycle();
    feed3_check(0, 1'b0);
    pulse_clear();

    // Asynchronous reset mid-frame
    run_stream(37, 100, 100, cyc);
    coeff_valid_i = 1'b0;
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("arst_word_valid", {31'b0, word_valid_o}, 32'd0);
    chk("arst_done", {31'b0, done_o}, 32'd0);
    chk("arst_coeff_ready", {31'b0, coeff_ready_o}, 32'd1);
    cycle();
    rst_ni = 1'b1;
    cycle();
    feed3_check(0, 1'b0);
    pulse_clear();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
